dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port data memory (1024 x 32, synchronous write, combinational read with mem_read enable).
- Shares the memory between the core load/store path (port 0) and a DMA/debug requester (port 1) using a valid/ready request handshake and a one-cycle response pulse.
- Converts byte-enabled stores into either a single full-word write or a read-modify-write sequence, since the memory supports only full-word writes.

Parameters:
DEPTH, 1024, number of 32-bit words in the attached memory
AW, 10, word-index width driven to the memory; equals clog2(DEPTH)

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
p0_req_valid  input  1  port 0 request present
p0_req_ready  output  1  port 0 request accepted this cycle
p0_req_write  input  1  1 = store, 0 = load
p0_req_addr  input  32  byte address; bits [1:0] ignored
p0_req_wdata  input  32  store data
p0_req_be  input  4  byte enables for store; bit n selects byte n
p0_resp_valid  output  1  one-cycle completion pulse
p0_resp_rdata  output  32  load data, valid with resp_valid
p0_resp_err  output  1  address out of range, valid with resp_valid
p1_* (same nine signals)  -  -  port 1, identical semantics
mem_read  output  1  memory read enable
mem_write  output  1  memory write enable, sampled on posedge
mem_address  output  32  word index {zeros, addr[AW+1:2]}
mem_write_data  output  32  full-word write data
mem_read_data  input  32  combinational read data

Behaviour:
- States: IDLE, ACCESS, RMW_WR, DONE. Reset forces IDLE, rr_ptr = 0, and drives every output to 0 (ready, resp_valid, resp_rdata, resp_err, mem_read, mem_write, mem_address, mem_write_data).
- IDLE: p*_req_ready is combinational. If only one port is valid, that port is granted. If both are valid, the port equal to rr_ptr is granted. On the handshake, latch write, addr, wdata, be and the port id, set rr_ptr to the other port, and go to ACCESS. Only one ready may be high in a cycle.
- Range check: addr[31:2] >= DEPTH sets err. Errored requests skip the memory (no mem_read/mem_write), go straight to DONE, and return rdata = 0 with resp_err = 1.
- be == 0 store: no memory access; go to DONE with err = 0.
- ACCESS with a load: mem_read = 1 and mem_address = index; register mem_read_data into the response holding register; go to DONE.
- ACCESS with a store and be == 4'hF: mem_write = 1 and mem_write_data = wdata (memory updates at the end of this cycle); go to DONE.
- ACCESS with a partial store: mem_read = 1; register the merged word (byte n = be[n] ? wdata byte n : mem_read_data byte n); go to RMW_WR.
- RMW_WR: mem_write = 1 with the merged word; go to DONE.
- DONE: the granted port's resp_valid = 1 for exactly one cycle, with rdata/err. rdata = 0 for stores. Return to IDLE. The other port's resp outputs stay 0.
- Latency from handshake cycle (cycle 0): load / full store / be == 0 / error respond in cycle 2; partial store responds in cycle 3. A new handshake is possible in the cycle after DONE.
- mem_address holds its last value when idle; mem_read and mem_write are 0 outside the states listed above.
- Port inputs are ignored while not in IDLE. A requester must hold valid and its fields stable until ready.
- Reset asserted in any state aborts the transaction next edge: no further memory write and no response pulse. If reset coincides with the RMW_WR cycle, mem_write is still combinationally high that cycle; that write is allowed.
- rr_ptr toggles only on a grant. A single valid port may be granted back-to-back indefinitely.

Test Plan:
- Memory preloaded RAM[i] = i; p0 load addr 0x14 -> mem_read high in cycle 1 with mem_address 5; p0_resp_valid in cycle 2 with rdata 0x00000005, err 0.
- p1 store addr 0x20, wdata 0xDEADBEEF, be 4'hF -> single mem_write cycle to index 8; a later load of 0x20 returns 0xDEADBEEF.
- p0 store addr 0x0C, wdata 0xAABBCCDD, be 4'b0101 (RAM[3] = 3) -> read cycle then write cycle with 0x00BB00DD; resp in cycle 3; a later load returns 0x00BB00DD.
- Both ports hold valid loads for 4 requests each, from reset -> grant order p0, p1, p0, p1…; each response pulses only on its own port.
- p1 load addr 0x1000 -> no mem_read or mem_write; cycle 2 p1_resp_err = 1, rdata 0. A be = 0 store -> no mem_write, resp err 0.
- Assert reset during ACCESS of a partial store -> no RMW_WR write, no resp pulse, all outputs 0, and next grant goes to p0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter with read-modify-write sequencing for a word-write-only data memory
module dmem_arbiter #(
  parameter int DEPTH = 1024,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req_valid,
  output logic        p0_req_ready,
  input  logic        p0_req_write,
  input  logic [31:0] p0_req_addr,
  input  logic [31:0] p0_req_wdata,
  input  logic [3:0]  p0_req_be,
  output logic        p0_resp_valid,
  output logic [31:0] p0_resp_rdata,
  output logic        p0_resp_err,
  input  logic        p1_req_valid,
  output logic        p1_req_ready,
  input  logic        p1_req_write,
  input  logic [31:0] p1_req_addr,
  input  logic [31:0] p1_req_wdata,
  input  logic [3:0]  p1_req_be,
  output logic        p1_resp_valid,
  output logic [31:0] p1_resp_rdata,
  output logic        p1_resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);
  typedef enum logic [1:0] {IDLE, ACCESS, RMW_WR, DONE} state_t;
  state_t state;
  logic port, write, err, rr_ptr, g0, g1, partial, unused_bits;
  logic [3:0] be;
  logic [AW-1:0] idx;
  logic [31:0] data, rdata, merged, sel_addr;
  // grant a lone requester outright; on contention the port rr_ptr names wins
  always_comb begin
    g1 = state == IDLE && !reset && p1_req_valid && (!p0_req_valid || rr_ptr);
    g0 = state == IDLE && !reset && p0_req_valid && !g1;
    sel_addr = g1 ? p1_req_addr : p0_req_addr;
    partial = write && !err && be != 4'h0 && be != 4'hF;
    merged = mem_read_data;
    for (int i = 0; i < 4; i++)
      if (be[i]) merged[8*i +: 8] = data[8*i +: 8];
  end
  assign unused_bits = ^sel_addr[1:0];
  assign p0_req_ready = g0;
  assign p1_req_ready = g1;
  assign mem_read = state == ACCESS && !err && (!write || partial);
  assign mem_write = (state == ACCESS && !err && write && be == 4'hF) || state == RMW_WR;
  assign mem_address = {{(32-AW){1'b0}}, idx};
  assign mem_write_data = data;
  assign p0_resp_valid = state == DONE && !port;
  assign p1_resp_valid = state == DONE && port;
  assign p0_resp_rdata = p0_resp_valid ? rdata : '0;
  assign p1_resp_rdata = p1_resp_valid ? rdata : '0;
  assign p0_resp_err = p0_resp_valid && err;
  assign p1_resp_err = p1_resp_valid && err;
  // sequencer: latch the granted request, access memory, merge partial stores, pulse the response
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= 1'b0;
      port <= 1'b0;
      write <= 1'b0;
      err <= 1'b0;
      be <= '0;
      idx <= '0;
      data <= '0;
      rdata <= '0;
    end else begin
      case (state)
        IDLE: if (g0 || g1) begin
          state <= ACCESS;
          port <= g1;
          rr_ptr <= g0;
          write <= g1 ? p1_req_write : p0_req_write;
          be <= g1 ? p1_req_be : p0_req_be;
          data <= g1 ? p1_req_wdata : p0_req_wdata;
          idx <= sel_addr[AW+1:2];
          err <= {2'b00, sel_addr[31:2]} >= 32'(DEPTH);
        end
        ACCESS: begin
          rdata <= (!write && !err) ? mem_read_data : '0;
          if (partial) data <= merged;
          state <= partial ? RMW_WR : DONE;
        end
        RMW_WR: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
